// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - coin sensor synchroniser, debouncer and N/D pulse arbiter
//
// Purpose: turns raw, bouncy nickel/dime sensor levels into single-cycle,
// spaced N/D pulses for the vending FSM, plus a reject pulse and a sticky
// stuck-sensor fault flag.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous reset, active low
//   nickel_raw in   raw nickel sensor level (asynchronous)
//   dime_raw   in   raw dime sensor level (asynchronous)
//   inhibit    in   1 = not accepting coins, qualified coins are rejected
//   N          out  one-cycle pulse per accepted nickel
//   D          out  one-cycle pulse per accepted dime
//   reject     out  one-cycle pulse per rejected coin event
//   fault      out  sticky stuck-sensor flag

module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES      = 2,
  parameter int STUCK_CYCLES    = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic nickel_raw,
  input  logic dime_raw,
  input  logic inhibit,
  output logic N,
  output logic D,
  output logic reject,
  output logic fault
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int SW = $clog2(STUCK_CYCLES + 1);

  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES);
  localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYCLES);
  localparam logic [SW-1:0] STK_MAX = SW'(STUCK_CYCLES);

  typedef enum logic [1:0] {
    ST_LOW  = 2'd0,
    ST_RISE = 2'd1,
    ST_HIGH = 2'd2,
    ST_FALL = 2'd3
  } ch_state_t;

  // Channel index 0 = nickel, 1 = dime throughout.
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  ch_state_t     r_state [2];
  logic [DW-1:0] r_cnt   [2];
  logic [SW-1:0] r_stk_n;
  logic [SW-1:0] r_stk_d;
  logic [1:0]    r_pend;
  logic [GW-1:0] r_gap;
  logic          r_n;
  logic          r_d;
  logic          r_reject;
  logic          r_fault;

  logic [1:0]    w_raw;
  logic [1:0]    w_det;
  logic [1:0]    w_single;
  logic [1:0]    w_new;
  logic [1:0]    w_eff;
  logic [SW-1:0] w_stk_nxt_n;
  logic [SW-1:0] w_stk_nxt_d;
  logic          w_fault_nxt;
  logic          w_rej;
  logic          w_gap_busy;
  logic          w_iss_n;
  logic          w_iss_d;

  assign w_raw = {dime_raw, nickel_raw};

  // Detect fires on the final qualifying sample so the pulse can be
  // registered on the same edge that moves the channel to HIGH.
  assign w_det[0] = (r_state[0] == ST_RISE) && r_sync2[0] && (r_cnt[0] == DEB_MAX);
  assign w_det[1] = (r_state[1] == ST_RISE) && r_sync2[1] && (r_cnt[1] == DEB_MAX);

  // Stuck counters saturate so the compare stays true without wrapping.
  assign w_stk_nxt_n = !r_sync2[0] ? '0 :
                       (r_stk_n == STK_MAX) ? r_stk_n : r_stk_n + SW'(1);
  assign w_stk_nxt_d = !r_sync2[1] ? '0 :
                       (r_stk_d == STK_MAX) ? r_stk_d : r_stk_d + SW'(1);
  assign w_fault_nxt = r_fault || (w_stk_nxt_n == STK_MAX) || (w_stk_nxt_d == STK_MAX);

  assign w_single[0] = w_det[0] & ~w_det[1];
  assign w_single[1] = w_det[1] & ~w_det[0];

  assign w_rej = (w_det[0] & w_det[1])
               | ((w_single[0] | w_single[1]) & inhibit)
               | (w_det[0] & r_pend[0])
               | (w_det[1] & r_pend[1]);

  // A fresh detect is folded into the pending set in the same cycle, so an
  // idle block issues the pulse one edge after the detect.
  assign w_new      = w_single & {2{~inhibit}} & ~r_pend;
  assign w_eff      = r_pend | w_new;
  assign w_gap_busy = (r_gap != '0);
  assign w_iss_n    = ~w_gap_busy & w_eff[0];
  assign w_iss_d    = ~w_gap_busy & ~w_eff[0] & w_eff[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      for (int ch = 0; ch < 2; ch++) begin
        r_state[ch] <= ST_LOW;
        r_cnt[ch]   <= '0;
      end
      r_stk_n  <= '0;
      r_stk_d  <= '0;
      r_pend   <= '0;
      r_gap    <= '0;
      r_n      <= 1'b0;
      r_d      <= 1'b0;
      r_reject <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;

      for (int ch = 0; ch < 2; ch++) begin
        case (r_state[ch])
          ST_LOW: begin
            if (r_sync2[ch]) begin
              r_state[ch] <= ST_RISE;
              r_cnt[ch]   <= DW'(1);
            end
          end
          ST_RISE: begin
            if (!r_sync2[ch])              r_state[ch] <= ST_LOW;
            else if (r_cnt[ch] == DEB_MAX) r_state[ch] <= ST_HIGH;
            else                           r_cnt[ch]   <= r_cnt[ch] + DW'(1);
          end
          ST_HIGH: begin
            if (!r_sync2[ch]) begin
              r_state[ch] <= ST_FALL;
              r_cnt[ch]   <= DW'(1);
            end
          end
          ST_FALL: begin
            if (r_sync2[ch])               r_state[ch] <= ST_HIGH;
            else if (r_cnt[ch] == DEB_MAX) r_state[ch] <= ST_LOW;
            else                           r_cnt[ch]   <= r_cnt[ch] + DW'(1);
          end
          default: r_state[ch] <= ST_LOW;
        endcase
      end

      r_stk_n <= w_stk_nxt_n;
      r_stk_d <= w_stk_nxt_d;
      r_fault <= w_fault_nxt;

      if (w_fault_nxt) begin
        r_n      <= 1'b0;
        r_d      <= 1'b0;
        r_reject <= 1'b0;
        r_pend   <= '0;
        r_gap    <= '0;
      end else begin
        r_n      <= w_iss_n;
        r_d      <= w_iss_d;
        r_reject <= w_rej;
        r_pend   <= w_eff & ~{w_iss_d, w_iss_n};
        if (w_iss_n || w_iss_d) r_gap <= GAP_MAX;
        else if (w_gap_busy)    r_gap <= r_gap - GW'(1);
      end
    end
  end

  assign N      = r_n;
  assign D      = r_d;
  assign reject = r_reject;
  assign fault  = r_fault;

endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - self-checking bench for coin_acceptor

module tb_coin_acceptor;

  localparam int DEB = 4;
  localparam int GAP = 2;
  localparam int STK = 20;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic nickel_raw = 1'b0;
  logic dime_raw = 1'b0;
  logic inhibit = 1'b0;
  logic N, D, reject, fault;

  int tests = 0;
  int fails = 0;

  coin_acceptor #(
    .DEBOUNCE_CYCLES(DEB),
    .GAP_CYCLES(GAP),
    .STUCK_CYCLES(STK)
  ) dut (
    .clk(clk),
    .reset(reset),
    .nickel_raw(nickel_raw),
    .dime_raw(dime_raw),
    .inhibit(inhibit),
    .N(N),
    .D(D),
    .reject(reject),
    .fault(fault)
  );

  always #5 clk = ~clk;

  // Reference model: level qualified by run lengths of the synced sample,
  // gap enforced by edge-number distance since the last issued pulse.
  bit m_s1 [2];
  bit m_s2 [2];
  int m_run1 [2];
  int m_run0 [2];
  bit m_lvl [2];
  bit m_pend [2];
  int m_edge = 0;
  int m_last = -100;
  bit m_fault = 0;
  bit exp_n = 0, exp_d = 0, exp_r = 0;

  task automatic model_step();
    bit raw [2];
    bit det [2];
    bit s;
    bit rej;
    m_edge++;
    exp_n = 0; exp_d = 0; exp_r = 0;
    if (!reset) begin
      for (int c = 0; c < 2; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_run1[c] = 0; m_run0[c] = 0;
        m_lvl[c] = 0; m_pend[c] = 0;
      end
      m_fault = 0;
      m_last = -100;
      return;
    end
    raw[0] = nickel_raw;
    raw[1] = dime_raw;
    for (int c = 0; c < 2; c++) begin
      s = m_s2[c];
      m_s2[c] = m_s1[c];
      m_s1[c] = raw[c];
      if (s) begin m_run1[c]++; m_run0[c] = 0; end
      else   begin m_run0[c]++; m_run1[c] = 0; end
      det[c] = 0;
      if (!m_lvl[c] && m_run1[c] == DEB + 1) begin det[c] = 1; m_lvl[c] = 1; end
      else if (m_lvl[c] && m_run0[c] == DEB + 1) m_lvl[c] = 0;
    end
    if (m_run1[0] >= STK || m_run1[1] >= STK) m_fault = 1;
    if (m_fault) begin
      m_pend[0] = 0; m_pend[1] = 0;
      return;
    end
    rej = 0;
    if (det[0] && det[1]) rej = 1;
    else begin
      for (int c = 0; c < 2; c++) begin
        if (det[c]) begin
          if (inhibit || m_pend[c]) rej = 1;
          else m_pend[c] = 1;
        end
      end
    end
    exp_r = rej;
    if (m_edge - m_last > GAP) begin
      if (m_pend[0])      begin exp_n = 1; m_pend[0] = 0; m_last = m_edge; end
      else if (m_pend[1]) begin exp_d = 1; m_pend[1] = 0; m_last = m_edge; end
    end
  endtask

  int qn[$];
  int qd[$];
  int qr[$];
  int t_edge;
  int f_edge;

  task automatic clear_rec();
    qn.delete(); qd.delete(); qr.delete();
    t_edge = 0;
    f_edge = -1;
  endtask

  task automatic check_val(input string nm, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // One clock: model predicts, DUT is sampled on the following falling edge.
  task automatic step();
    model_step();
    @(negedge clk);
    tests++;
    if ({N, D, reject, fault} !== {exp_n, exp_d, exp_r, m_fault}) begin
      fails++;
      $display("FAIL model edge %0d: got N D rej flt=%b%b%b%b want %b%b%b%b",
               m_edge, N, D, reject, fault, exp_n, exp_d, exp_r, m_fault);
    end
    t_edge++;
    if (N === 1'b1)      qn.push_back(t_edge);
    if (D === 1'b1)      qd.push_back(t_edge);
    if (reject === 1'b1) qr.push_back(t_edge);
    if (fault === 1'b1 && f_edge < 0) f_edge = t_edge;
  endtask

  task automatic do_reset();
    reset = 1'b0; nickel_raw = 1'b0; dime_raw = 1'b0; inhibit = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic run_pattern(input logic [31:0] np, input logic [31:0] dp,
                             input logic [31:0] ip, input int len);
    for (int i = 0; i < len; i++) begin
      nickel_raw = (i < 32) ? np[i] : 1'b0;
      dime_raw   = (i < 32) ? dp[i] : 1'b0;
      inhibit    = (i < 32) ? ip[i] : 1'b0;
      step();
    end
  endtask

  function automatic int first_of();
    int f = -1;
    if (qn.size() > 0 && (f < 0 || qn[0] < f)) f = qn[0];
    if (qd.size() > 0 && (f < 0 || qd[0] < f)) f = qd[0];
    if (qr.size() > 0 && (f < 0 || qr[0] < f)) f = qr[0];
    return f;
  endfunction

  typedef struct {
    string       name;
    logic [31:0] n_pat;
    logic [31:0] d_pat;
    logic [31:0] i_pat;
    int          n_cnt;
    int          d_cnt;
    int          r_cnt;
    int          first;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{"clean_nickel", 32'h0000_0FFF, 32'h0,         32'h0,         1, 0, 0, 7};
    vecs[1] = '{"bounce",       32'h0000_7FED, 32'h0,         32'h0,         1, 0, 0, 12};
    vecs[2] = '{"simultaneous", 32'h0000_03FF, 32'h0000_03FF, 32'h0,         0, 0, 1, 7};
    vecs[3] = '{"inhibit_dime", 32'h0,         32'h0000_0FFF, 32'hFFFF_FFFF, 0, 0, 1, 7};
    vecs[4] = '{"clean_dime",   32'h0,         32'h0000_0FFF, 32'h0,         0, 1, 0, 7};
    vecs[5] = '{"short4",       32'h0000_000F, 32'h0,         32'h0,         0, 0, 0, -1};
    vecs[6] = '{"exact5",       32'h0000_001F, 32'h0,         32'h0,         1, 0, 0, 7};
    vecs[7] = '{"two_nickels",  32'h003F_C0FF, 32'h0,         32'h0,         2, 0, 0, 7};
    vecs[8] = '{"inh_then_ok",  32'h0,         32'h00FF_00FF, 32'h0000_FFFF, 0, 1, 1, 7};

    @(negedge clk);
    do_reset();
    check_val("reset_N", N, 0);
    check_val("reset_fault", fault, 0);

    foreach (vecs[k]) begin
      do_reset();
      clear_rec();
      run_pattern(vecs[k].n_pat, vecs[k].d_pat, vecs[k].i_pat, 44);
      check_val({vecs[k].name, "_n"},     qn.size(), vecs[k].n_cnt);
      check_val({vecs[k].name, "_d"},     qd.size(), vecs[k].d_cnt);
      check_val({vecs[k].name, "_rej"},   qr.size(), vecs[k].r_cnt);
      check_val({vecs[k].name, "_first"}, first_of(), vecs[k].first);
    end

    // Spacing: dime detect one cycle ahead of nickel detect.
    do_reset();
    clear_rec();
    run_pattern(32'h0000_0FFE, 32'h0000_07FF, 32'h0, 30);
    check_val("spacing_d_cnt", qd.size(), 1);
    check_val("spacing_n_cnt", qn.size(), 1);
    check_val("spacing_d_edge", (qd.size() > 0) ? qd[0] : -1, 7);
    check_val("spacing_n_edge", (qn.size() > 0) ? qn[0] : -1, 10);

    // Stuck dime, then a nickel while faulted, then reset clears fault.
    do_reset();
    clear_rec();
    run_pattern(32'h0, 32'h3FFF_FFFF, 32'h0, 40);
    check_val("stuck_d_cnt", qd.size(), 1);
    check_val("stuck_d_edge", (qd.size() > 0) ? qd[0] : -1, 7);
    check_val("stuck_fault_edge", f_edge, 22);
    clear_rec();
    run_pattern(32'h0000_0FFF, 32'h0, 32'h0, 20);
    check_val("stuck_no_n", qn.size(), 0);
    check_val("stuck_fault_held", fault, 1);
    do_reset();
    check_val("stuck_fault_cleared", fault, 0);

    // Reset in the middle of a debounce.
    do_reset();
    clear_rec();
    nickel_raw = 1'b1;
    for (int i = 0; i < 4; i++) step();
    reset = 1'b0; nickel_raw = 1'b0;
    step(); step();
    reset = 1'b1;
    for (int i = 0; i < 15; i++) step();
    check_val("rst_mid_debounce_no_n", qn.size() + qd.size() + qr.size(), 0);

    // Reset with a nickel pending behind the gap window.
    do_reset();
    clear_rec();
    run_pattern(32'h0000_01FE, 32'h0000_01FF, 32'h0, 8);
    check_val("rst_pend_d_edge", (qd.size() > 0) ? qd[0] : -1, 7);
    reset = 1'b0; nickel_raw = 1'b0; dime_raw = 1'b0;
    step(); step();
    reset = 1'b1;
    for (int i = 0; i < 15; i++) step();
    check_val("rst_pend_no_n", qn.size(), 0);

    // Randomised bouncy traffic against the model.
    begin
      int  rem [2];
      bit  lvl [2];
      do_reset();
      rem[0] = 1; rem[1] = 1; lvl[0] = 0; lvl[1] = 0;
      for (int i = 0; i < 1500; i++) begin
        for (int c = 0; c < 2; c++) begin
          rem[c]--;
          if (rem[c] <= 0) begin
            lvl[c] = ~lvl[c];
            rem[c] = lvl[c] ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 10));
          end
        end
        nickel_raw = lvl[0];
        dime_raw   = lvl[1];
        inhibit    = ($urandom_range(0, 3) == 0);
        reset      = ($urandom_range(0, 299) != 0);
        step();
      end
      reset = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
- Front-end stage that feeds the vending FSM its N and D inputs.
- Takes raw, asynchronous, bouncy coin-sensor levels and synchronises and debounces them.
- Emits single-cycle, arbitrated N (nickel) and D (dime) pulses with guaranteed spacing.
- Produces a reject pulse for invalid or unaccepted coins and a sticky fault flag for stuck sensors.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synced samples required to qualify a level change (>=1).
- GAP_CYCLES, 2: minimum idle cycles between successive N/D pulses (0 allows back-to-back).
- STUCK_CYCLES, 1000: consecutive synced-high cycles on one channel that declare a fault (> DEBOUNCE_CYCLES).
- Counter widths are derived from these with $clog2.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- nickel_raw  input  1  raw nickel sensor level; asynchronous to clk.
- dime_raw  input  1  raw dime sensor level; asynchronous to clk.
- inhibit  input  1  1 = machine not accepting coins; qualified coins are rejected.
- N  output  1  one-cycle pulse per accepted nickel.
- D  output  1  one-cycle pulse per accepted dime.
- reject  output  1  one-cycle pulse per rejected coin event.
- fault  output  1  sticky stuck-sensor flag.

Behaviour:
- Reset (reset=0, asynchronous): N, D, reject and fault go to 0. Synchronisers, counters and pending flags clear, and both channels enter LOW.
- Each raw input passes through a 2-flop synchroniser; call the output s.
- Per-channel FSM, four states:
  - LOW: s=1 loads count=1 and moves to RISE.
  - RISE: s=0 returns to LOW. When count reaches DEBOUNCE_CYCLES, the channel raises a one-cycle detect strobe and moves to HIGH; otherwise count increments.
  - HIGH: s=0 loads count=1 and moves to FALL.
  - FALL: s=1 returns to HIGH. When count reaches DEBOUNCE_CYCLES, moves to LOW.
  - Exactly one detect is produced per qualified insertion; bounces restart the count.
- Latency: with a raw input stable high, N or D is high in the cycle beginning DEBOUNCE_CYCLES+2 rising edges after the first edge that samples raw=1. If a gap window or queued coin intervenes, the pulse comes later.
- Arbitration, evaluated each cycle:
  - Both channels detect in the same cycle: reject=1 next cycle. Neither coin is queued, and the gap window does not start.
  - Single detect with inhibit=1: reject=1 next cycle, no pending flag set. inhibit is sampled at detect only; coins already pending are still delivered.
  - Single detect with inhibit=0: set that channel's pending flag.
  - Detect on a channel whose pending flag is already set: reject=1 next cycle, and the existing pending flag is kept.
- Issue rules:
  - When no gap window is active and any pending flag is set, the block pulses N (nickel pending) or D (dime pending) and clears that flag.
  - If both are pending, nickel goes first and dime follows after the gap.
  - N and D are never high in the same cycle.
  - After an N or D in cycle t, neither may assert in cycles t+1 through t+GAP_CYCLES.
- reject timing:
  - reject is independent of the gap window and may coincide with N or D.
  - When several reject causes occur in one cycle, they produce a single pulse.
- Stuck detection:
  - A per-channel counter increments while s=1 and clears while s=0.
  - When either counter reaches STUCK_CYCLES, fault goes to 1 and stays at 1 until reset.
  - While fault=1: N, D and reject are forced to 0, pending flags clear, and new detects are dropped.
- Reset asserted mid-debounce or with coins pending: everything is discarded, and no pulse appears after reset releases.
- Outputs are registered; none is combinational from an input.

Test Plan:
- Clean nickel (DEBOUNCE_CYCLES=4): nickel_raw rises and holds 12 cycles -> N=1 for exactly one cycle, 6 edges after the first sampled high; D=0, reject=0.
- Bounce: nickel_raw goes 1,0,1,1,0, then stays 1 for 10 cycles -> exactly one N, timed from the start of the final stable run.
- Simultaneous: both raw inputs rise on the same edge and hold 10 cycles -> exactly one reject pulse, N=D=0.
- Spacing (GAP_CYCLES=2): dime detect in cycle t-1, nickel detect in cycle t -> D in cycle t, N in cycle t+3.
- Inhibit: inhibit=1 with one dime inserted -> reject pulse, D=0. Then inhibit=0 with a second dime -> D pulse.
- Stuck/reset (STUCK_CYCLES=20): dime_raw held high 30 cycles -> one D, then fault=1 after 20 synced-high cycles. A subsequent nickel produces no N. reset=0 clears fault. Asserting reset=0 mid-debounce yields no pulse after release.
